// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared types and helpers for the keypad matrix emulator.
// A key code packs the matrix position as {row[1:0], col[1:0]}.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [2:0] {
        IDLE,
        BNC_PRESS,
        HOLD,
        BNC_RELEASE,
        GAP
    } emu_state_t;

    function automatic logic [1:0] key_row(input key_code_t code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] key_col(input key_code_t code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Request handshake, matrix buses and debug status of the keypad emulator.
// A press is accepted on the clk edge where key_valid && key_ready; nothing is queued while not ready.
interface keypad_matrix_emulator_if;
    import keypad_pkg::*;

    logic            key_valid;
    key_code_t       key_code;
    logic            key_ready;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic            contact;
    logic            busy;
    logic            done;
    emu_state_t      dbg_state;

    modport master (
        output key_valid, key_code, col_in,
        input  key_ready, row_out, contact, busy, done, dbg_state
    );

    modport slave (
        input  key_valid, key_code, col_in,
        output key_ready, row_out, contact, busy, done, dbg_state
    );

endinterface

// File: rtl/keypad_matrix_emulator_contact_timer.sv
// Phase down-counter plus bounce toggle generator, both reloaded on every phase entry.
// expire_o flags the last cycle of a phase, toggle_o the last cycle of each bounce period.
module contact_timer #(
    parameter int CW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] length_i,
    input  logic [PW-1:0] period_i,
    output logic          expire_o,
    output logic          toggle_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] per_q, per_d;

    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (load_i) begin
            cnt_d = length_i - CW'(1);
            per_d = period_i - PW'(1);
        end else begin
            // Phase counter parks at zero; only a reload moves it again.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
            per_d = (per_q == '0) ? (period_i - PW'(1)) : (per_q - PW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

    assign expire_o = (cnt_q == '0);
    assign toggle_o = (per_q == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad-side emulation of a 4x4 matrix: plays a timed, bouncing key press on request
// and returns row levels combinationally from the column drive like a real switch.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2000,
    parameter int BOUNCE_CYCLES = 200,
    parameter int BOUNCE_PERIOD = 16,
    parameter int GAP_CYCLES    = 500,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    keypad_matrix_emulator_if.slave bus
);

    localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
    localparam int MAX_LEN = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int PW      = $clog2(BOUNCE_PERIOD + 1);

    emu_state_t    state_q, state_d;
    logic          contact_q, contact_d;
    key_code_t     key_q;
    logic          ready;
    logic          accept;
    logic          load;
    logic [CW-1:0] length;
    logic          expire;
    logic          toggle;
    logic          col_seen;

    assign ready  = (state_q == IDLE) && !rst;
    assign accept = bus.key_valid && ready;

    contact_timer #(
        .CW(CW),
        .PW(PW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .length_i (length),
        .period_i (PW'(BOUNCE_PERIOD)),
        .expire_o (expire),
        .toggle_o (toggle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (accept) state_d = (BOUNCE_CYCLES == 0) ? HOLD : BNC_PRESS;
            BNC_PRESS:   if (expire) state_d = HOLD;
            HOLD:        if (expire) state_d = (BOUNCE_CYCLES == 0) ? GAP : BNC_RELEASE;
            BNC_RELEASE: if (expire) state_d = GAP;
            GAP:         if (expire) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.key_ready = ready;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == GAP) && expire && !rst;
        load          = (state_d != state_q);
        case (state_d)
            BNC_PRESS, BNC_RELEASE: length = CW'(BOUNCE_CYCLES);
            HOLD:                   length = CW'(HOLD_CYCLES);
            GAP:                    length = CW'(GAP_CYCLES);
            default:                length = '0;
        endcase
        // Each phase starts from a fixed contact level; bounce phases then toggle it.
        contact_d = contact_q;
        if (load) begin
            contact_d = (state_d == BNC_PRESS) || (state_d == HOLD);
        end else if (toggle && ((state_q == BNC_PRESS) || (state_q == BNC_RELEASE))) begin
            contact_d = !contact_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            contact_q <= 1'b0;
            key_q     <= '0;
        end else begin
            contact_q <= contact_d;
            if (accept) begin
                key_q <= bus.key_code;
            end
        end
    end

    // Only the latched column matters, even if the scanner drives several at once.
    assign col_seen = bus.col_in[key_col(key_q)];

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            if (ACTIVE_LOW) begin
                bus.row_out[r] = !(contact_q && (key_row(key_q) == 2'(r)) && !col_seen);
            end else begin
                bus.row_out[r] = contact_q && (key_row(key_q) == 2'(r)) && col_seen;
            end
        end
    end

    assign bus.contact   = contact_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: three configurations share one stimulus stream,
// checked every cycle against a timeline model plus directed tables for the corner cases.
module tb_keypad_matrix_emulator;
    import keypad_pkg::*;

    localparam int NDUT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] col_in;

    keypad_matrix_emulator_if ifa ();
    keypad_matrix_emulator_if ifb ();
    keypad_matrix_emulator_if ifc ();

    assign ifa.key_valid = key_valid;
    assign ifa.key_code  = key_code;
    assign ifa.col_in    = col_in;
    assign ifb.key_valid = key_valid;
    assign ifb.key_code  = key_code;
    assign ifb.col_in    = col_in;
    assign ifc.key_valid = key_valid;
    assign ifc.key_code  = key_code;
    assign ifc.col_in    = ~col_in;

    // dut_a: bouncing, active-high; dut_b: no bounce, active-high; dut_c: dut_b in active-low form
    keypad_matrix_emulator #(
        .HOLD_CYCLES(6), .BOUNCE_CYCLES(8), .BOUNCE_PERIOD(2), .GAP_CYCLES(4), .ACTIVE_LOW(1'b0)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    keypad_matrix_emulator #(
        .HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(16), .GAP_CYCLES(4), .ACTIVE_LOW(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    keypad_matrix_emulator #(
        .HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(16), .GAP_CYCLES(4), .ACTIVE_LOW(1'b1)
    ) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    // ---------------- reference model ----------------
    int         bnc_m [NDUT] = '{8, 0, 0};
    int         hold_m[NDUT] = '{6, 8, 8};
    int         per_m [NDUT] = '{2, 16, 16};
    int         tot_m [NDUT] = '{26, 12, 12};
    logic       al_m  [NDUT] = '{1'b0, 1'b0, 1'b1};
    int         t_m   [NDUT] = '{0, 0, 0};
    logic [3:0] key_m [NDUT] = '{4'h0, 4'h0, 4'h0};

    // t_m = cycles since the accepting edge (0 = idle); the whole press is a fixed timeline.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                t_m[d] <= 0;
            end else if (t_m[d] == 0) begin
                if (key_valid) begin
                    t_m[d]   <= 1;
                    key_m[d] <= key_code;
                end
            end else if (t_m[d] == tot_m[d]) begin
                t_m[d] <= 0;
            end else begin
                t_m[d] <= t_m[d] + 1;
            end
        end
    end

    function automatic logic exp_contact(int t, int b, int h, int p);
        if (t <= 0)         return 1'b0;
        if (t <= b)         return (((t - 1) / p) % 2) == 0;
        if (t <= b + h)     return 1'b1;
        if (t <= 2 * b + h) return (((t - b - h - 1) / p) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_row(logic c, logic [3:0] key, logic [3:0] col, logic al);
        logic [3:0] seen;
        logic [3:0] r;
        seen = al ? ~col : col;
        r = (c && seen[key[1:0]]) ? (4'b0001 << key[3:2]) : 4'b0000;
        return al ? ~r : r;
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int d, input logic [3:0] act, input logic [3:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d @%0t: got %b, expected %b", name, d, $time, act, want);
        end
    endtask

    task automatic chk_dut(input int d, input logic rdy, input logic bsy, input logic dn,
                           input logic ct, input logic [3:0] row, input logic [3:0] col);
        logic c;
        int   t;
        t = t_m[d];
        c = exp_contact(t, bnc_m[d], hold_m[d], per_m[d]);
        chk("model_key_ready", d, rdy, (t == 0) && !rst);
        chk("model_busy", d, bsy, t != 0);
        chk("model_done", d, dn, (t == tot_m[d]) && !rst);
        chk("model_contact", d, ct, c);
        chk("model_row_out", d, row, exp_row(c, key_m[d], col, al_m[d]));
    endtask

    // One clock: outputs are sampled 2 time units after the edge, then inputs may change.
    task automatic tick();
        @(posedge clk);
        #2;
        chk_dut(0, ifa.key_ready, ifa.busy, ifa.done, ifa.contact, ifa.row_out, col_in);
        chk_dut(1, ifb.key_ready, ifb.busy, ifb.done, ifb.contact, ifb.row_out, col_in);
        chk_dut(2, ifc.key_ready, ifc.busy, ifc.done, ifc.contact, ifc.row_out, ~col_in);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ifa.key_ready && ifb.key_ready && ifc.key_ready) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 0, 4'(n < 200), 4'd1);
    endtask

    // ---------------- directed tables ----------------
    typedef struct {
        logic [3:0] col;
        logic [3:0] exp_ah;
        logic [3:0] exp_al;
    } row_vec_t;

    typedef struct {
        logic [3:0] row;
        logic       busy;
        logic       done;
        logic       ready;
    } press_vec_t;

    row_vec_t   idle_tab [4];
    row_vec_t   sel_tab  [4];
    press_vec_t press_tab[13];
    logic [0:25] pat_a;

    initial begin
        idle_tab[0] = '{4'b0001, 4'b0000, 4'b1111};
        idle_tab[1] = '{4'b0010, 4'b0000, 4'b1111};
        idle_tab[2] = '{4'b0100, 4'b0000, 4'b1111};
        idle_tab[3] = '{4'b1000, 4'b0000, 4'b1111};
        sel_tab[0]  = '{4'b0001, 4'b0000, 4'b1111};
        sel_tab[1]  = '{4'b1000, 4'b1000, 4'b0111};
        sel_tab[2]  = '{4'b1001, 4'b1000, 4'b0111};
        sel_tab[3]  = '{4'b0111, 4'b0000, 4'b1111};
        for (int i = 0; i < 8; i++) press_tab[i] = '{4'b0010, 1'b1, 1'b0, 1'b0};
        for (int i = 8; i < 11; i++) press_tab[i] = '{4'b0000, 1'b1, 1'b0, 1'b0};
        press_tab[11] = '{4'b0000, 1'b1, 1'b1, 1'b0};
        press_tab[12] = '{4'b0000, 1'b0, 1'b0, 1'b1};
        pat_a = 26'b11001100_111111_00110011_0000;

        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; col_in = 4'b0001;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state, then idle with the column drive walking.
        for (int i = 0; i < 4; i++) begin
            col_in = idle_tab[i].col;
            tick();
            chk("idle_row_a", 0, ifa.row_out, idle_tab[i].exp_ah);
            chk("idle_row_c", 2, ifc.row_out, idle_tab[i].exp_al);
            chk("idle_ready_b", 1, ifb.key_ready, 1'b1);
            chk("idle_busy_b", 1, ifb.busy, 1'b0);
        end

        // No-bounce press on dut_b/dut_c and the bounce pattern on dut_a, same accept edge.
        col_in = 4'b0100; key_code = 4'b0110; key_valid = 1'b1;
        for (int t = 1; t <= 27; t++) begin
            tick();
            if (t <= 13) begin
                chk("np_row_b", 1, ifb.row_out, press_tab[t-1].row);
                chk("np_row_c", 2, ifc.row_out, ~press_tab[t-1].row);
                chk("np_busy_b", 1, ifb.busy, press_tab[t-1].busy);
                chk("np_done_b", 1, ifb.done, press_tab[t-1].done);
                chk("np_ready_b", 1, ifb.key_ready, press_tab[t-1].ready);
            end
            if (t <= 26) begin
                chk("bnc_contact_a", 0, ifa.contact, pat_a[t-1]);
                chk("bnc_busy_a", 0, ifa.busy, 1'b1);
            end else begin
                chk("bnc_busy_end_a", 0, ifa.busy, 1'b0);
            end
            chk("bnc_done_a", 0, ifa.done, 4'(t == 26));
            if (t == 1) key_valid = 1'b0;
            if (t == 3) key_code = 4'b0001;
        end

        // Column selectivity while dut_b/dut_c hold key 15.
        key_code = 4'b1111; key_valid = 1'b1; col_in = 4'b0001;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            col_in = sel_tab[i].col;
            tick();
            chk("sel_row_b", 1, ifb.row_out, sel_tab[i].exp_ah);
            chk("sel_row_c", 2, ifc.row_out, sel_tab[i].exp_al);
        end
        wait_idle();

        // Back-pressure: valid held with code 3, then 9 waits until the cycle after done.
        col_in = 4'b0010; key_code = 4'd3; key_valid = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 5) chk("bp_row_old_col", 1, ifb.row_out, 4'b0000);
            if (t == 6) chk("bp_row_latched", 1, ifb.row_out, 4'b0001);
            if (t == 12) begin
                chk("bp_done", 1, ifb.done, 1'b1);
                chk("bp_not_ready_at_done", 1, ifb.key_ready, 1'b0);
            end
            if (t == 13) begin
                chk("bp_ready_after_done", 1, ifb.key_ready, 1'b1);
                chk("bp_done_cleared", 1, ifb.done, 1'b0);
            end
            if (t == 14) begin
                chk("bp_busy_new_key", 1, ifb.busy, 1'b1);
                chk("bp_row_new_key", 1, ifb.row_out, 4'b0100);
            end
            if (t == 1) key_code = 4'd9;
            if (t == 5) col_in = 4'b1000;
            if (t == 6) col_in = 4'b0010;
            if (t == 14) key_valid = 1'b0;
        end
        wait_idle();

        // Reset in the middle of the press.
        key_code = 4'b0110; col_in = 4'b0100; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_contact_b", 1, ifb.contact, 1'b0);
        chk("rst_busy_b", 1, ifb.busy, 1'b0);
        chk("rst_row_b", 1, ifb.row_out, 4'b0000);
        chk("rst_row_c", 2, ifc.row_out, 4'b1111);
        chk("rst_contact_a", 0, ifa.contact, 1'b0);
        chk("rst_ready_held", 1, ifb.key_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", 1, ifb.key_ready, 1'b1);
        repeat (20) begin
            tick();
            chk("rst_no_done_b", 1, ifb.done, 1'b0);
            chk("rst_no_done_a", 0, ifa.done, 1'b0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_code  = 4'($urandom_range(0, 15));
            col_in    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : (4'b0001 << $urandom_range(0, 3));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; key_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
